// File: rtl/audio_block_packer_if.sv
// Byte-stream input and block-stream output of the audio block packer.
// slave = packer side, master = source/cipher side.
interface audio_block_packer_if #(
  parameter int BLOCK_BYTES = 8
);
  localparam int BW = $clog2(BLOCK_BYTES + 1);

  logic [7:0]               audio_data;
  logic                     audio_valid;
  logic                     audio_last;
  logic                     audio_ready;
  logic [8*BLOCK_BYTES-1:0] block_data;
  logic                     block_valid;
  logic                     block_ready;
  logic                     block_last;
  logic [BW-1:0]            block_bytes;

  modport slave (
    input  audio_data, audio_valid, audio_last, block_ready,
    output audio_ready, block_data, block_valid, block_last, block_bytes
  );

  modport master (
    output audio_data, audio_valid, audio_last, block_ready,
    input  audio_ready, block_data, block_valid, block_last, block_bytes
  );
endinterface

// File: rtl/audio_block_packer.sv
// Packs 8-bit audio samples into BLOCK_BYTES-wide cipher blocks, first byte
// in the most significant lane, padding a short final block with PAD_BYTE.
module audio_block_packer #(
  parameter int          BLOCK_BYTES = 8,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic clk,
  input  logic rst_n,
  audio_block_packer_if.slave pk
);
  localparam int CW = $clog2(BLOCK_BYTES);
  localparam int BW = $clog2(BLOCK_BYTES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {FILL, PAD, HOLD} state_t;

  state_t                   state_reg;
  logic [CW-1:0]            cnt_reg;
  logic [8*BLOCK_BYTES-1:0] data_reg;
  logic [8*BLOCK_BYTES-1:0] data_next;
  logic                     valid_reg;
  logic                     last_reg;
  logic [BW-1:0]            bytes_reg;
  logic                     ready_reg;

  logic                     accept;
  logic                     write_en;
  logic [7:0]               write_byte;
  logic [BLOCK_BYTES-1:0]   lane_sel;

  assign accept     = (state_reg == FILL) && pk.audio_valid && ready_reg;
  assign write_en   = accept || (state_reg == PAD);
  assign write_byte = (state_reg == PAD) ? PAD_BYTE : pk.audio_data;

  // Lane gi holds the byte written at count BLOCK_BYTES-1-gi.
  for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_lane
    assign lane_sel[gi] = write_en && (cnt_reg == CW'(BLOCK_BYTES - 1 - gi));
  end

  always_comb begin
    data_next = data_reg;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (lane_sel[i]) data_next[8*i +: 8] = write_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FILL;
      cnt_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      bytes_reg <= '0;
      ready_reg <= 1'b0;
    end else begin
      data_reg <= data_next;
      case (state_reg)
        FILL: begin
          ready_reg <= 1'b1;
          if (accept) begin
            if (cnt_reg == CNT_MAX) begin
              state_reg <= HOLD;
              valid_reg <= 1'b1;
              last_reg  <= pk.audio_last;
              bytes_reg <= BW'(BLOCK_BYTES);
              ready_reg <= 1'b0;
            end else if (pk.audio_last) begin
              state_reg <= PAD;
              last_reg  <= 1'b1;
              bytes_reg <= BW'(cnt_reg) + BW'(1);
              cnt_reg   <= cnt_reg + 1'b1;
              ready_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        PAD: begin
          // Count stays at the top lane through HOLD; the take clears it.
          if (cnt_reg == CNT_MAX) begin
            state_reg <= HOLD;
            valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          if (pk.block_ready) begin
            state_reg <= FILL;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= FILL;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign pk.audio_ready = ready_reg;
  assign pk.block_data  = data_reg;
  assign pk.block_valid = valid_reg;
  assign pk.block_last  = last_reg;
  assign pk.block_bytes = bytes_reg;
endmodule

// File: tb/tb_audio_block_packer.sv
// Scoreboard bench for audio_block_packer with BLOCK_BYTES=8: expected blocks
// are queued as bytes are accepted and checked when the cipher side takes them.
module tb_audio_block_packer;
  localparam int BB = 8;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  bytes;
    logic        last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];
  logic [63:0] m_data;
  int          m_cnt;
  logic        took_prev;
  logic        hold_prev;
  logic [63:0] data_prev;

  audio_block_packer_if #(.BLOCK_BYTES(BB)) bif ();

  audio_block_packer #(.BLOCK_BYTES(BB), .PAD_BYTE(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pk    (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] d, input logic last);
    exp_t e;
    m_data[8*(BB-1-m_cnt) +: 8] = d;
    m_cnt++;
    if (m_cnt == BB || last) begin
      e.data  = m_data;
      e.bytes = 4'(m_cnt);
      e.last  = last;
      sb.push_back(e);
      m_cnt  = 0;
      m_data = '0;
    end
  endtask

  task automatic model_flush();
    m_cnt  = 0;
    m_data = '0;
    sb.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic last);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bif.audio_valid = 1'b1;
    bif.audio_data  = d;
    bif.audio_last  = last;
    forever begin
      acc = bif.audio_ready;
      @(negedge clk);
      if (acc) break;
      n++;
      if (n > 100) begin
        check_eq("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    if (acc) model_byte(d, last);
    bif.audio_valid = 1'b0;
    bif.audio_last  = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!bif.block_valid && c < 50) begin
      if (bif.audio_ready !== 1'b0) check_eq("ready_in_pad", {63'd0, bif.audio_ready}, 64'd0);
      @(negedge clk);
      c++;
    end
    if (!bif.block_valid) check_eq("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Block-side monitor, sampled well clear of the rising edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      took_prev = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (took_prev) begin
        check_eq("valid_after_take", {63'd0, bif.block_valid}, 64'd0);
        check_eq("ready_after_take", {63'd0, bif.audio_ready}, 64'd1);
      end
      if (bif.block_valid) begin
        check_eq("ready_in_hold", {63'd0, bif.audio_ready}, 64'd0);
        if (hold_prev) check_eq("hold_stable", bif.block_data, data_prev);
      end
      took_prev = 1'b0;
      hold_prev = 1'b0;
      if (bif.block_valid && bif.block_ready) begin
        $display("block data=%h bytes=%0d last=%0b", bif.block_data, bif.block_bytes, bif.block_last);
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("block_data", bif.block_data, e.data);
          check_eq("block_bytes", {60'd0, bif.block_bytes}, {60'd0, e.bytes});
          check_eq("block_last", {63'd0, bif.block_last}, {63'd0, e.last});
        end
        took_prev = 1'b1;
      end else if (bif.block_valid) begin
        hold_prev = 1'b1;
        data_prev = bif.block_data;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"},  bif.block_data, 64'd0);
    check_eq({tag, "_valid"}, {63'd0, bif.block_valid}, 64'd0);
    check_eq({tag, "_last"},  {63'd0, bif.block_last}, 64'd0);
    check_eq({tag, "_bytes"}, {60'd0, bif.block_bytes}, 64'd0);
    check_eq({tag, "_ready"}, {63'd0, bif.audio_ready}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    checks = 0; failures = 0;
    m_data = '0; m_cnt = 0;
    took_prev = 1'b0; hold_prev = 1'b0; data_prev = '0;
    rst_n = 1'b0;
    bif.audio_data = 8'h00; bif.audio_valid = 1'b0; bif.audio_last = 1'b0;
    bif.block_ready = 1'b0;
    idle(3);
    check_all_zero("reset");

    // Release: audio_ready rises on the first edge after release.
    rst_n = 1'b1;
    #1 check_eq("ready_pre_edge", {63'd0, bif.audio_ready}, 64'd0);
    @(negedge clk);
    check_eq("ready_post_edge", {63'd0, bif.audio_ready}, 64'd1);

    // Full block, back-to-back.
    bif.block_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    check_eq("full_valid_next", {63'd0, bif.block_valid}, 64'd1);
    check_eq("full_data_const", bif.block_data, 64'h0102030405060708);
    idle(2);

    // Short final block: 3 real bytes, 5 pad cycles.
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b1);
    wait_valid(c);
    check_eq("short_pad_cycles", 64'(c), 64'd5);
    check_eq("short_data_const", bif.block_data, 64'hA1A2A30000000000);
    idle(2);

    // Exact fit with last on the 8th byte: no pad cycles.
    for (int i = 0; i < 8; i++) send(8'hB0 + 8'(i), i == 7);
    wait_valid(c);
    check_eq("exact_pad_cycles", 64'(c), 64'd0);
    idle(2);

    // Backpressure with toggling audio_valid.
    bif.block_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), 1'b0);
    wait_valid(c);
    for (int i = 0; i < 10; i++) begin
      bif.audio_valid = (i % 2 == 0);
      bif.audio_data  = 8'hEE;
      @(negedge clk);
    end
    bif.audio_valid = 1'b0;
    bif.block_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_ready_after", {63'd0, bif.audio_ready}, 64'd1);

    // Gapped input: junk data presented while audio_valid is low.
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i), 1'b0);
      bif.audio_data = 8'hFF;
      @(negedge clk);
    end
    idle(3);

    // Reset after 5 bytes of a block.
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 1'b0);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    model_flush();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 1'b0);
    idle(3);

    // Reset during HOLD.
    bif.block_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 1'b0);
    wait_valid(c);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_hold");
    model_flush();
    @(negedge clk);
    rst_n = 1'b1;
    bif.block_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 1'b0);
    idle(4);

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
